// File: rtl/mem_hier_pkg.sv
`default_nettype none
// ============================================================================
// mem_hier_pkg - FSM state encoding and line geometry helpers for mem_hier_ctrl
// Revision: 1.0
// ============================================================================
package mem_hier_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EVICT  = 2'd1,
    D_FILL = 2'd2,
    I_FILL = 2'd3
  } state_e;

  function automatic int calc_line_w(input int word_w, input int wpl);
    return word_w * wpl;
  endfunction

  function automatic int calc_off_w(input int wpl);
    return $clog2(wpl);
  endfunction

  function automatic int calc_laddr_w(input int addr_w, input int wpl);
    return addr_w - $clog2(wpl);
  endfunction

  function automatic int calc_tag_w(input int addr_w, input int wpl, input int index_w);
    return calc_laddr_w(addr_w, wpl) - index_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_hier_ctrl_line_word_ops.sv
`default_nettype none
// ============================================================================
// line_word_ops - select one word of a cache line and merge one word into it
// Revision: 1.0
// ============================================================================
module line_word_ops
  import mem_hier_pkg::*;
#(
  parameter int WORD_W = 16,
  parameter int WPL    = 4,
  localparam int LINE_W = calc_line_w(WORD_W, WPL),
  localparam int OFF_W  = calc_off_w(WPL)
) (
  input  logic [LINE_W-1:0] line_i,
  input  logic [OFF_W-1:0]  off_i,
  input  logic [WORD_W-1:0] word_i,
  output logic [WORD_W-1:0] word_o,
  output logic [LINE_W-1:0] line_o
);

  logic [WORD_W-1:0] w_words [WPL];

  for (genvar g = 0; g < WPL; g++) begin : g_word
    assign w_words[g] = line_i[g*WORD_W +: WORD_W];
    assign line_o[g*WORD_W +: WORD_W] = (off_i == OFF_W'(g)) ? word_i : w_words[g];
  end

  assign word_o = w_words[off_i];

endmodule
`default_nettype wire

// File: rtl/mem_hier_ctrl.sv
`default_nettype none
// ============================================================================
// mem_hier_ctrl - split I/D direct-mapped cache controller over a unified line memory
// Revision: 1.0
// ============================================================================
module mem_hier_ctrl
  import mem_hier_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int WORD_W  = 16,
  parameter int WPL     = 4,
  parameter int INDEX_W = 6,
  parameter int D_PRIO  = 1,
  parameter int CNT_W   = 16,
  localparam int LINE_W  = calc_line_w(WORD_W, WPL),
  localparam int OFF_W   = calc_off_w(WPL),
  localparam int LADDR_W = calc_laddr_w(ADDR_W, WPL),
  localparam int TAG_W   = calc_tag_w(ADDR_W, WPL, INDEX_W)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [ADDR_W-1:0]  i_addr,
  input  logic [ADDR_W-1:0]  d_addr,
  input  logic               mem_rd,
  input  logic               mem_wr,
  input  logic [WORD_W-1:0]  wr_data,
  output logic [WORD_W-1:0]  instr,
  output logic [WORD_W-1:0]  data,
  output logic               i_rdy,
  output logic               d_rdy,
  input  logic               ic_hit,
  input  logic [LINE_W-1:0]  ic_line,
  output logic               ic_we,
  input  logic               dc_hit,
  input  logic               dc_dirty,
  input  logic [TAG_W-1:0]   dc_tag,
  input  logic [LINE_W-1:0]  dc_line,
  output logic               dc_we,
  output logic               dc_wdirty,
  output logic [LINE_W-1:0]  dc_wdata,
  output logic [LADDR_W-1:0] mem_addr,
  output logic               mem_re,
  output logic               mem_we,
  output logic [LINE_W-1:0]  mem_wdata,
  input  logic [LINE_W-1:0]  mem_rdata,
  input  logic               mem_rdy,
  output logic [CNT_W-1:0]   i_miss_cnt,
  output logic [CNT_W-1:0]   d_miss_cnt
);

  state_e state_q, state_d;

  logic [LADDR_W-1:0] d_laddr_q;
  logic [LADDR_W-1:0] i_laddr_q;
  logic [OFF_W-1:0]   i_off_q;
  logic [LADDR_W-1:0] vic_addr_q;
  logic [LINE_W-1:0]  vic_line_q;
  logic [CNT_W-1:0]   i_cnt_q, i_cnt_d;
  logic [CNT_W-1:0]   d_cnt_q, d_cnt_d;

  logic w_d_req, w_d_miss, w_i_miss, w_take_d, w_take_i;
  logic w_in_dfill, w_in_ifill;

  logic [LINE_W-1:0] w_d_src_line, w_d_merge, w_i_src_line, w_i_line_unused;
  logic [OFF_W-1:0]  w_i_off;
  logic [WORD_W-1:0] w_d_word, w_i_word;

  assign w_d_req  = mem_rd | mem_wr;
  assign w_d_miss = w_d_req & ~dc_hit;
  assign w_i_miss = ~ic_hit;
  // On a simultaneous miss only the winner is taken; the loser re-presents in IDLE later.
  assign w_take_d = w_d_miss & ((D_PRIO != 0) | ~w_i_miss);
  assign w_take_i = w_i_miss & ~w_take_d;

  assign w_in_dfill = (state_q == D_FILL);
  assign w_in_ifill = (state_q == I_FILL);

  // D side merges into the fill line during D_FILL, into the hit line otherwise.
  assign w_d_src_line = w_in_dfill ? mem_rdata : dc_line;
  assign w_i_src_line = w_in_ifill ? mem_rdata : ic_line;
  assign w_i_off      = w_in_ifill ? i_off_q : i_addr[OFF_W-1:0];

  line_word_ops #(
    .WORD_W (WORD_W),
    .WPL    (WPL)
  ) u_d_ops (
    .line_i (w_d_src_line),
    .off_i  (d_addr[OFF_W-1:0]),
    .word_i (wr_data),
    .word_o (w_d_word),
    .line_o (w_d_merge)
  );

  line_word_ops #(
    .WORD_W (WORD_W),
    .WPL    (WPL)
  ) u_i_ops (
    .line_i (w_i_src_line),
    .off_i  (w_i_off),
    .word_i ({WORD_W{1'b0}}),
    .word_o (w_i_word),
    .line_o (w_i_line_unused)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (w_take_d)      state_d = dc_dirty ? EVICT : D_FILL;
        else if (w_take_i) state_d = I_FILL;
      end
      EVICT:   if (mem_rdy) state_d = D_FILL;
      D_FILL:  if (mem_rdy) state_d = IDLE;
      I_FILL:  if (mem_rdy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    i_rdy     = 1'b0;
    d_rdy     = 1'b0;
    ic_we     = 1'b0;
    dc_we     = 1'b0;
    dc_wdirty = 1'b0;
    dc_wdata  = (w_in_dfill && !mem_wr) ? mem_rdata : w_d_merge;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    instr     = w_i_word;
    data      = w_d_word;
    // Strobes are forced low while rst_n is asserted, whatever the state register holds.
    if (rst_n) begin
      unique case (state_q)
        IDLE: begin
          i_rdy     = ic_hit;
          d_rdy     = ~w_d_miss;
          dc_we     = mem_wr & dc_hit;
          dc_wdirty = mem_wr & dc_hit;
        end
        EVICT: begin
          mem_we    = 1'b1;
          mem_addr  = vic_addr_q;
          mem_wdata = vic_line_q;
        end
        D_FILL: begin
          mem_re   = 1'b1;
          mem_addr = d_laddr_q;
          if (mem_rdy) begin
            dc_we     = 1'b1;
            d_rdy     = 1'b1;
            dc_wdirty = mem_wr;
          end
        end
        I_FILL: begin
          mem_re   = 1'b1;
          mem_addr = i_laddr_q;
          if (mem_rdy) begin
            ic_we = 1'b1;
            i_rdy = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign i_cnt_d = (&i_cnt_q) ? i_cnt_q : i_cnt_q + 1'b1;
  assign d_cnt_d = (&d_cnt_q) ? d_cnt_q : d_cnt_q + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      d_laddr_q  <= '0;
      i_laddr_q  <= '0;
      i_off_q    <= '0;
      vic_addr_q <= '0;
      vic_line_q <= '0;
      i_cnt_q    <= '0;
      d_cnt_q    <= '0;
    end else if (state_q == IDLE) begin
      if (w_take_d) begin
        d_laddr_q <= d_addr[ADDR_W-1:OFF_W];
        d_cnt_q   <= d_cnt_d;
        if (dc_dirty) begin
          vic_addr_q <= {dc_tag, d_addr[OFF_W +: INDEX_W]};
          vic_line_q <= dc_line;
        end
      end
      if (w_take_i) begin
        i_laddr_q <= i_addr[ADDR_W-1:OFF_W];
        i_off_q   <= i_addr[OFF_W-1:0];
        i_cnt_q   <= i_cnt_d;
      end
    end
  end

  assign i_miss_cnt = i_cnt_q;
  assign d_miss_cnt = d_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_hier_ctrl.sv
`default_nettype none
// ============================================================================
// tb_mem_hier_ctrl - hit vectors plus scoreboarded miss/fill sequences on three builds
// Revision: 1.0
// ============================================================================
module tb_mem_hier_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Shared stimulus for the D_PRIO=1 build (a_) and the D_PRIO=0, CNT_W=2 build (b_)
  logic        rst0_n, rst1_n;
  logic [15:0] i_addr, d_addr, wr_data;
  logic        mem_rd, mem_wr, ic_hit, dc_hit, dc_dirty, mem_rdy;
  logic [7:0]  dc_tag;
  logic [63:0] ic_line, dc_line, mem_rdata;

  logic [15:0] a_instr, a_data, a_icnt, a_dcnt;
  logic        a_i_rdy, a_d_rdy, a_ic_we, a_dc_we, a_dc_wdirty, a_mem_re, a_mem_we;
  logic [63:0] a_dc_wdata, a_mem_wdata;
  logic [13:0] a_mem_addr;

  logic [15:0] b_instr, b_data;
  logic [1:0]  b_icnt, b_dcnt;
  logic        b_i_rdy, b_d_rdy, b_ic_we, b_dc_we, b_dc_wdirty, b_mem_re, b_mem_we;
  logic [63:0] b_dc_wdata, b_mem_wdata;
  logic [13:0] b_mem_addr;

  // WPL=8, WORD_W=32 build (c_)
  logic         c_rst_n;
  logic [15:0]  c_i_addr, c_d_addr;
  logic [31:0]  c_wr_data, c_instr, c_data;
  logic         c_mem_rd, c_mem_wr, c_ic_hit, c_dc_hit, c_dc_dirty, c_mem_rdy;
  logic         c_i_rdy, c_d_rdy, c_ic_we, c_dc_we, c_dc_wdirty, c_mem_re, c_mem_we;
  logic [6:0]   c_dc_tag;
  logic [255:0] c_ic_line, c_dc_line, c_mem_rdata, c_dc_wdata, c_mem_wdata;
  logic [12:0]  c_mem_addr;
  logic [15:0]  c_icnt, c_dcnt;

  mem_hier_ctrl #(.D_PRIO(1), .CNT_W(16)) u_dut_a (
    .clk(clk), .rst_n(rst0_n), .i_addr(i_addr), .d_addr(d_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .wr_data(wr_data), .instr(a_instr), .data(a_data), .i_rdy(a_i_rdy), .d_rdy(a_d_rdy),
    .ic_hit(ic_hit), .ic_line(ic_line), .ic_we(a_ic_we), .dc_hit(dc_hit), .dc_dirty(dc_dirty),
    .dc_tag(dc_tag), .dc_line(dc_line), .dc_we(a_dc_we), .dc_wdirty(a_dc_wdirty), .dc_wdata(a_dc_wdata),
    .mem_addr(a_mem_addr), .mem_re(a_mem_re), .mem_we(a_mem_we), .mem_wdata(a_mem_wdata),
    .mem_rdata(mem_rdata), .mem_rdy(mem_rdy), .i_miss_cnt(a_icnt), .d_miss_cnt(a_dcnt));

  mem_hier_ctrl #(.D_PRIO(0), .CNT_W(2)) u_dut_b (
    .clk(clk), .rst_n(rst1_n), .i_addr(i_addr), .d_addr(d_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .wr_data(wr_data), .instr(b_instr), .data(b_data), .i_rdy(b_i_rdy), .d_rdy(b_d_rdy),
    .ic_hit(ic_hit), .ic_line(ic_line), .ic_we(b_ic_we), .dc_hit(dc_hit), .dc_dirty(dc_dirty),
    .dc_tag(dc_tag), .dc_line(dc_line), .dc_we(b_dc_we), .dc_wdirty(b_dc_wdirty), .dc_wdata(b_dc_wdata),
    .mem_addr(b_mem_addr), .mem_re(b_mem_re), .mem_we(b_mem_we), .mem_wdata(b_mem_wdata),
    .mem_rdata(mem_rdata), .mem_rdy(mem_rdy), .i_miss_cnt(b_icnt), .d_miss_cnt(b_dcnt));

  mem_hier_ctrl #(.WPL(8), .WORD_W(32)) u_dut_c (
    .clk(clk), .rst_n(c_rst_n), .i_addr(c_i_addr), .d_addr(c_d_addr), .mem_rd(c_mem_rd), .mem_wr(c_mem_wr),
    .wr_data(c_wr_data), .instr(c_instr), .data(c_data), .i_rdy(c_i_rdy), .d_rdy(c_d_rdy),
    .ic_hit(c_ic_hit), .ic_line(c_ic_line), .ic_we(c_ic_we), .dc_hit(c_dc_hit), .dc_dirty(c_dc_dirty),
    .dc_tag(c_dc_tag), .dc_line(c_dc_line), .dc_we(c_dc_we), .dc_wdirty(c_dc_wdirty), .dc_wdata(c_dc_wdata),
    .mem_addr(c_mem_addr), .mem_re(c_mem_re), .mem_we(c_mem_we), .mem_wdata(c_mem_wdata),
    .mem_rdata(c_mem_rdata), .mem_rdy(c_mem_rdy), .i_miss_cnt(c_icnt), .d_miss_cnt(c_dcnt));

  // Observation mux: sel1 routes the b_ build to the shared checker tasks
  logic        sel1;
  logic        o_i_rdy, o_d_rdy, o_ic_we, o_dc_we, o_dc_wdirty, o_mem_re, o_mem_we;
  logic [15:0] o_instr, o_data, o_icnt, o_dcnt;
  logic [63:0] o_dc_wdata, o_mem_wdata;
  logic [13:0] o_mem_addr;

  assign o_i_rdy     = sel1 ? b_i_rdy     : a_i_rdy;
  assign o_d_rdy     = sel1 ? b_d_rdy     : a_d_rdy;
  assign o_ic_we     = sel1 ? b_ic_we     : a_ic_we;
  assign o_dc_we     = sel1 ? b_dc_we     : a_dc_we;
  assign o_dc_wdirty = sel1 ? b_dc_wdirty : a_dc_wdirty;
  assign o_mem_re    = sel1 ? b_mem_re    : a_mem_re;
  assign o_mem_we    = sel1 ? b_mem_we    : a_mem_we;
  assign o_instr     = sel1 ? b_instr     : a_instr;
  assign o_data      = sel1 ? b_data      : a_data;
  assign o_icnt      = sel1 ? {14'd0, b_icnt} : a_icnt;
  assign o_dcnt      = sel1 ? {14'd0, b_dcnt} : a_dcnt;
  assign o_dc_wdata  = sel1 ? b_dc_wdata  : a_dc_wdata;
  assign o_mem_wdata = sel1 ? b_mem_wdata : a_mem_wdata;
  assign o_mem_addr  = sel1 ? b_mem_addr  : a_mem_addr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard of expected memory operations, pushed in the order they must occur
  typedef struct {
    logic        wr;
    logic [13:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    int          lat;
  } op_t;
  op_t sb[$];

  logic        cap_i_rdy, cap_d_rdy, cap_ic_we, cap_dc_we, cap_dc_wdirty;
  logic [15:0] cap_instr, cap_data, cap_icnt, cap_dcnt;
  logic [63:0] cap_dc_wdata;

  task automatic wait_op(output bit ok);
    int n = 0;
    @(negedge clk);
    while (!(o_mem_re || o_mem_we) && n < 40) begin
      @(negedge clk);
      n++;
    end
    ok = o_mem_re || o_mem_we;
    if (!ok) chk("mem op timeout", 64'd0, 64'd1);
  endtask

  task automatic serve();
    op_t op;
    bit  ok;
    wait_op(ok);
    if (!ok) return;
    if (sb.size() == 0) begin
      chk("unexpected mem op", 64'd1, 64'd0);
      return;
    end
    op = sb.pop_front();
    chk("mem_we", 64'(o_mem_we), 64'(op.wr));
    chk("mem_re", 64'(o_mem_re), 64'(!op.wr));
    chk("mem_addr", 64'(o_mem_addr), 64'(op.addr));
    if (op.wr) chk("mem_wdata", o_mem_wdata, op.wdata);
    for (int k = 0; k < op.lat; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("mem_addr hold", 64'(o_mem_addr), 64'(op.addr));
      chk("mem strobe hold", 64'({o_mem_we, o_mem_re}), op.wr ? 64'd2 : 64'd1);
    end
    @(posedge clk); #1;
    mem_rdy   = 1'b1;
    mem_rdata = op.rdata;
    @(negedge clk);
    cap_i_rdy     = o_i_rdy;
    cap_d_rdy     = o_d_rdy;
    cap_ic_we     = o_ic_we;
    cap_dc_we     = o_dc_we;
    cap_dc_wdirty = o_dc_wdirty;
    cap_instr     = o_instr;
    cap_data      = o_data;
    cap_icnt      = o_icnt;
    cap_dcnt      = o_dcnt;
    cap_dc_wdata  = o_dc_wdata;
    @(posedge clk); #1;
    mem_rdy = 1'b0;
  endtask

  typedef struct {
    logic        ic_hit, mem_rd, mem_wr, dc_hit, rdy;
    logic [15:0] i_addr, d_addr, wr_data;
    logic        e_i_rdy, e_d_rdy, e_dc_we, e_chk_data;
    logic [15:0] e_instr, e_data;
    logic [63:0] e_wdata;
  } vec_t;
  vec_t vt[6];

  localparam logic [63:0] ICL = 64'hDDDD_CCCC_BBBB_AAAA;
  localparam logic [63:0] DCL = 64'h4444_3333_2222_1111;
  localparam logic [63:0] R1  = 64'h1004_1003_1002_1001;
  localparam logic [63:0] R2  = 64'h2004_2003_2002_2001;

  int exp_icnt0 = 0, exp_dcnt0 = 0, exp_icnt1 = 0, exp_dcnt1 = 0;

  initial begin
    bit  ok;
    op_t op;

    vt[0] = '{1, 1, 0, 1, 0, 16'h0001, 16'h0002, 16'h0000, 1, 1, 0, 1, 16'hBBBB, 16'h3333, 64'd0};
    vt[1] = '{1, 0, 0, 0, 0, 16'h0003, 16'h0000, 16'h0000, 1, 1, 0, 0, 16'hDDDD, 16'h0000, 64'd0};
    vt[2] = '{1, 0, 1, 1, 0, 16'h0000, 16'h0001, 16'hBEEF, 1, 1, 1, 0, 16'hAAAA, 16'h0000, 64'h4444_3333_BEEF_1111};
    vt[3] = '{1, 0, 1, 1, 1, 16'h0002, 16'h0003, 16'h5A5A, 1, 1, 1, 0, 16'hCCCC, 16'h0000, 64'h5A5A_3333_2222_1111};
    vt[4] = '{1, 1, 0, 1, 1, 16'h0001, 16'h0001, 16'h0000, 1, 1, 0, 1, 16'hBBBB, 16'h2222, 64'd0};
    vt[5] = '{1, 0, 1, 1, 0, 16'h0002, 16'h0000, 16'hCAFE, 1, 1, 1, 0, 16'hCCCC, 16'h0000, 64'h4444_3333_2222_CAFE};

    sel1 = 0; rst0_n = 0; rst1_n = 0; c_rst_n = 0;
    i_addr = 0; d_addr = 0; wr_data = 0; mem_rd = 0; mem_wr = 1; ic_hit = 1; dc_hit = 1;
    dc_dirty = 0; dc_tag = 0; ic_line = ICL; dc_line = DCL; mem_rdata = 0; mem_rdy = 1;
    c_i_addr = 0; c_d_addr = 0; c_wr_data = 0; c_mem_rd = 0; c_mem_wr = 0; c_ic_hit = 1;
    c_dc_hit = 1; c_dc_dirty = 0; c_dc_tag = 0; c_ic_line = 0; c_dc_line = 0; c_mem_rdata = 0;
    c_mem_rdy = 0;

    // Reset: hits and a store present, yet no strobe may rise
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("rst i_rdy", 64'(a_i_rdy), 64'd0);
      chk("rst d_rdy", 64'(a_d_rdy), 64'd0);
      chk("rst dc_we", 64'(a_dc_we), 64'd0);
      chk("rst mem strobes", 64'({a_mem_re, a_mem_we}), 64'd0);
      chk("rst b rdy", 64'({b_i_rdy, b_d_rdy}), 64'd0);
    end
    chk("rst i_miss_cnt", 64'(a_icnt), 64'd0);
    chk("rst d_miss_cnt", 64'(a_dcnt), 64'd0);
    @(posedge clk); #1;
    rst0_n = 1; mem_wr = 0; mem_rdy = 0;

    // IDLE hit vectors
    for (int v = 0; v < 6; v++) begin
      @(posedge clk); #1;
      ic_hit = vt[v].ic_hit; mem_rd = vt[v].mem_rd; mem_wr = vt[v].mem_wr; dc_hit = vt[v].dc_hit;
      mem_rdy = vt[v].rdy; i_addr = vt[v].i_addr; d_addr = vt[v].d_addr; wr_data = vt[v].wr_data;
      @(negedge clk);
      chk($sformatf("v%0d i_rdy", v), 64'(o_i_rdy), 64'(vt[v].e_i_rdy));
      chk($sformatf("v%0d d_rdy", v), 64'(o_d_rdy), 64'(vt[v].e_d_rdy));
      chk($sformatf("v%0d instr", v), 64'(o_instr), 64'(vt[v].e_instr));
      chk($sformatf("v%0d dc_we", v), 64'(o_dc_we), 64'(vt[v].e_dc_we));
      chk($sformatf("v%0d dc_wdirty", v), 64'(o_dc_wdirty), 64'(vt[v].e_dc_we));
      chk($sformatf("v%0d ic_we", v), 64'(o_ic_we), 64'd0);
      chk($sformatf("v%0d mem strobes", v), 64'({o_mem_re, o_mem_we}), 64'd0);
      if (vt[v].e_chk_data) chk($sformatf("v%0d data", v), 64'(o_data), 64'(vt[v].e_data));
      if (vt[v].e_dc_we)    chk($sformatf("v%0d dc_wdata", v), o_dc_wdata, vt[v].e_wdata);
    end
    @(posedge clk); #1;
    mem_rd = 0; mem_wr = 0; mem_rdy = 0; dc_hit = 1;

    // Reset held two cycles in the middle of an I fill
    ic_hit = 0; i_addr = 16'h0300;
    sb.push_back('{1'b0, 14'h00C0, 64'd0, R2, 1});
    wait_op(ok);
    if (ok) begin
      op = sb.pop_front();
      chk("ifill addr", 64'(o_mem_addr), 64'(op.addr));
    end
    exp_icnt0 = 1;
    chk("ifill icnt", 64'(o_icnt), 64'(exp_icnt0));
    @(posedge clk); #1;
    rst0_n = 0; mem_rdy = 1; ic_hit = 1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("midrst mem_re", 64'(o_mem_re), 64'd0);
      chk("midrst ic_we", 64'(o_ic_we), 64'd0);
      chk("midrst i_rdy", 64'(o_i_rdy), 64'd0);
      @(posedge clk); #1;
    end
    rst0_n = 1; mem_rdy = 0; exp_icnt0 = 0;
    @(negedge clk);
    chk("post-rst i_rdy", 64'(o_i_rdy), 64'd1);
    chk("post-rst mem_re", 64'(o_mem_re), 64'd0);
    chk("post-rst icnt", 64'(o_icnt), 64'(exp_icnt0));

    // Dirty store miss: write back victim {A5, index 0D}, then fill line 048D and merge
    @(posedge clk); #1;
    mem_wr = 1; dc_hit = 0; dc_dirty = 1; dc_tag = 8'hA5; d_addr = 16'h1234; wr_data = 16'h7777;
    dc_line = 64'h0123_4567_89AB_CDEF;
    sb.push_back('{1'b1, 14'h294D, 64'h0123_4567_89AB_CDEF, 64'd0, 2});
    sb.push_back('{1'b0, 14'h048D, 64'd0, 64'h8888_9999_AAAA_BBBB, 1});
    exp_dcnt0++;
    @(negedge clk);
    chk("dmiss d_rdy", 64'(o_d_rdy), 64'd0);
    serve();
    serve();
    chk("store fill dc_we", 64'(cap_dc_we), 64'd1);
    chk("store fill dirty", 64'(cap_dc_wdirty), 64'd1);
    chk("store fill d_rdy", 64'(cap_d_rdy), 64'd1);
    chk("store fill merge", cap_dc_wdata, 64'h8888_9999_AAAA_7777);
    chk("store fill dcnt", 64'(cap_dcnt), 64'(exp_dcnt0));
    chk("store fill icnt", 64'(cap_icnt), 64'(exp_icnt0));
    mem_wr = 0; dc_dirty = 0; dc_line = DCL;

    // Simultaneous clean misses, D first
    ic_hit = 0; mem_rd = 1; i_addr = 16'h0105; d_addr = 16'h0208;
    sb.push_back('{1'b0, 14'h0082, 64'd0, R1, 1});
    sb.push_back('{1'b0, 14'h0041, 64'd0, R2, 2});
    exp_dcnt0++;
    serve();
    chk("dprio1 d_rdy", 64'(cap_d_rdy), 64'd1);
    chk("dprio1 i_rdy early", 64'(cap_i_rdy), 64'd0);
    chk("dprio1 data", 64'(cap_data), 64'h1001);
    chk("dprio1 load wdata", cap_dc_wdata, R1);
    chk("dprio1 load dirty", 64'(cap_dc_wdirty), 64'd0);
    chk("dprio1 icnt", 64'(cap_icnt), 64'(exp_icnt0));
    chk("dprio1 dcnt", 64'(cap_dcnt), 64'(exp_dcnt0));
    mem_rd = 0;
    exp_icnt0++;
    serve();
    chk("dprio1 i_rdy", 64'(cap_i_rdy), 64'd1);
    chk("dprio1 ic_we", 64'(cap_ic_we), 64'd1);
    chk("dprio1 instr", 64'(cap_instr), 64'h2002);
    chk("dprio1 icnt2", 64'(cap_icnt), 64'(exp_icnt0));
    ic_hit = 1;

    // D_PRIO=0 build: I served first, then D; then counter saturation at 2 bits
    @(posedge clk); #1;
    rst0_n = 0; rst1_n = 1; sel1 = 1;
    @(posedge clk); #1;
    ic_hit = 0; mem_rd = 1; dc_hit = 0;
    sb.push_back('{1'b0, 14'h0041, 64'd0, R2, 1});
    sb.push_back('{1'b0, 14'h0082, 64'd0, R1, 1});
    exp_icnt1++;
    serve();
    chk("dprio0 i_rdy", 64'(cap_i_rdy), 64'd1);
    chk("dprio0 d_rdy early", 64'(cap_d_rdy), 64'd0);
    chk("dprio0 instr", 64'(cap_instr), 64'h2002);
    chk("dprio0 icnt", 64'(cap_icnt), 64'(exp_icnt1));
    chk("dprio0 dcnt", 64'(cap_dcnt), 64'(exp_dcnt1));
    ic_hit = 1;
    exp_dcnt1++;
    serve();
    chk("dprio0 d_rdy", 64'(cap_d_rdy), 64'd1);
    chk("dprio0 data", 64'(cap_data), 64'h1001);
    chk("dprio0 dcnt2", 64'(cap_dcnt), 64'(exp_dcnt1));
    mem_rd = 0; dc_hit = 1;

    ic_hit = 0; i_addr = 16'h0044;
    for (int k = 0; k < 5; k++) begin
      sb.push_back('{1'b0, 14'h0011, 64'd0, R2, 0});
      if (exp_icnt1 < 3) exp_icnt1++;
      serve();
      chk($sformatf("sat fill%0d i_rdy", k), 64'(cap_i_rdy), 64'd1);
      chk($sformatf("sat fill%0d icnt", k), 64'(cap_icnt), 64'(exp_icnt1));
    end
    ic_hit = 1;
    @(negedge clk);
    chk("sat hold icnt", 64'(o_icnt), 64'd3);

    // WPL=8, WORD_W=32 build: load miss at word 7
    @(posedge clk); #1;
    rst1_n = 0; c_rst_n = 1;
    c_mem_rd = 1; c_dc_hit = 0; c_d_addr = 16'h1237;
    for (int k = 0; k < 8; k++) c_mem_rdata[k*32 +: 32] = 32'hC0DE_0000 + 32'(k);
    begin
      int n = 0;
      @(negedge clk);
      while (!c_mem_re && n < 40) begin
        @(negedge clk);
        n++;
      end
    end
    chk("w8 mem_re", 64'(c_mem_re), 64'd1);
    chk("w8 mem_addr", 64'(c_mem_addr), 64'h0246);
    @(posedge clk); #1;
    c_mem_rdy = 1;
    @(negedge clk);
    chk("w8 data", 64'(c_data), 64'hC0DE_0007);
    chk("w8 d_rdy", 64'(c_d_rdy), 64'd1);
    chk("w8 dc_we", 64'(c_dc_we), 64'd1);
    chk("w8 dcnt", 64'(c_dcnt), 64'd1);
    @(posedge clk); #1;
    c_mem_rdy = 0; c_mem_rd = 0; c_dc_hit = 1;

    chk("scoreboard empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
